// File: rtl/ar_pkg.sv
// Shared types and status codes for the freeze-cartridge INT7 sequencer.
package ar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_FROZEN  = 2'd2,
    ST_HOLDOFF = 2'd3
  } ar_state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'b11;
  localparam logic [1:0] CAUSE_FREEZE = 2'b00;
  localparam logic [1:0] CAUSE_BREAK  = 2'b01;
  localparam logic [1:0] CAUSE_RESET  = 2'b10;

endpackage

// File: rtl/ar_bp_prio_enc.sv
// Lowest-index-wins priority encoder over the breakpoint comparator hits.
module ar_bp_prio_enc #(
  parameter int NBP = 4
) (
  input  logic [NBP-1:0] hits,
  output logic           hit,
  output logic [2:0]     idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    hit = |hits;
    idx = 3'd0;
    for (int i = NBP - 1; i >= 0; i--) begin
      if (hits[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/ar_int7_sequencer.sv
// Freeze-cartridge level-7 interrupt sequencer: arbitrates reset-trap, freeze
// key and breakpoint requests, then walks REQ -> FROZEN -> HOLDOFF -> IDLE.
// Optional build macro AR_REQ_TIMEOUT_EN adds an unacknowledged-INT7 timeout
// and the sticky req_timeout output.
module ar_int7_sequencer
  import ar_pkg::*;
#(
  parameter int NBP     = 4,
  parameter int HOLDOFF = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           boot,
  input  logic           freeze_btn,
  input  logic           reset_trap,
  input  logic [NBP-1:0] bp_hit,
  input  logic           bp_arm,
  input  logic           int7_ack,
  input  logic           exit_wr,
  input  logic           ovl_clr,
  output logic           int7,
  output logic           active,
  output logic           ovl,
  output logic [1:0]     cause,
  output logic [2:0]     bp_idx,
  output logic           busy
`ifdef AR_REQ_TIMEOUT_EN
  ,
  output logic           req_timeout
`endif
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  ar_state_e   state, state_n;
  logic        int7_n, active_n, ovl_n;
  logic [1:0]  cause_n;
  logic [2:0]  bp_idx_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic        freeze_q;
  logic        freeze_req, bp_req, bp_any;
  logic [2:0]  bp_enc_idx;
  logic        clr_all;

`ifdef AR_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          req_timeout_n;
`endif

  assign clr_all    = reset | ~enable;
  assign freeze_req = freeze_btn & ~freeze_q;
  assign bp_req     = bp_arm & bp_any;
  assign busy       = (state != ST_IDLE);

  ar_bp_prio_enc #(.NBP(NBP)) u_bp_enc (
    .hits (bp_hit),
    .hit  (bp_any),
    .idx  (bp_enc_idx)
  );

  // Freeze key history; also loaded during reset so no false edge follows it.
  always_ff @(posedge clk) begin
    freeze_q <= freeze_btn;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      state    <= ST_IDLE;
      int7     <= 1'b0;
      active   <= 1'b0;
      ovl      <= 1'b0;
      cause    <= CAUSE_NONE;
      bp_idx   <= 3'd0;
      hold_cnt <= '0;
`ifdef AR_REQ_TIMEOUT_EN
      tmo_cnt     <= '0;
      req_timeout <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      int7     <= int7_n;
      active   <= active_n;
      ovl      <= ovl_n;
      cause    <= cause_n;
      bp_idx   <= bp_idx_n;
      hold_cnt <= hold_n;
`ifdef AR_REQ_TIMEOUT_EN
      tmo_cnt     <= tmo_n;
      req_timeout <= req_timeout_n;
`endif
    end
  end

  // Next-state and next-output logic; every value holds unless a state acts.
  always_comb begin
    state_n  = state;
    int7_n   = int7;
    active_n = active;
    ovl_n    = ovl;
    cause_n  = cause;
    bp_idx_n = bp_idx;
    hold_n   = hold_cnt;
`ifdef AR_REQ_TIMEOUT_EN
    tmo_n         = tmo_cnt;
    req_timeout_n = req_timeout;
`endif
    unique case (state)
      ST_IDLE: begin
        if (ovl_clr) ovl_n = 1'b0;
        if (!boot && (reset_trap || freeze_req || bp_req)) begin
          state_n = ST_REQ;
          int7_n  = 1'b1;
          if (reset_trap) begin
            cause_n = CAUSE_RESET;
          end else if (freeze_req) begin
            cause_n = CAUSE_FREEZE;
          end else begin
            cause_n  = CAUSE_BREAK;
            bp_idx_n = bp_enc_idx;
          end
`ifdef AR_REQ_TIMEOUT_EN
          tmo_n = TW'(TIMEOUT - 1);
`endif
        end
      end
      ST_REQ: begin
        if (int7_ack) begin
          state_n  = ST_FROZEN;
          int7_n   = 1'b0;
          active_n = 1'b1;
          ovl_n    = 1'b1;
        end
`ifdef AR_REQ_TIMEOUT_EN
        else if (tmo_cnt == '0) begin
          state_n       = ST_IDLE;
          int7_n        = 1'b0;
          cause_n       = CAUSE_NONE;
          req_timeout_n = 1'b1;
        end else begin
          tmo_n = tmo_cnt - 1'b1;
        end
`endif
      end
      ST_FROZEN: begin
        if (ovl_clr) ovl_n = 1'b0;
        if (exit_wr) begin
          state_n  = ST_HOLDOFF;
          active_n = 1'b0;
          hold_n   = HW'(HOLDOFF - 1);
        end
      end
      ST_HOLDOFF: begin
        if (ovl_clr) ovl_n = 1'b0;
        if (hold_cnt == '0) state_n = ST_IDLE;
        else                hold_n  = hold_cnt - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ar_int7_sequencer.sv
// Directed bench for ar_int7_sequencer (NBP=4, HOLDOFF=16, TIMEOUT=16).
module tb_ar_int7_sequencer;
  import ar_pkg::*;

  logic       clk = 1'b0;
  logic       reset, enable, boot, freeze_btn, reset_trap, bp_arm;
  logic [3:0] bp_hit;
  logic       int7_ack, exit_wr, ovl_clr;
  logic       int7, active, ovl, busy;
  logic [1:0] cause;
  logic [2:0] bp_idx;
`ifdef AR_REQ_TIMEOUT_EN
  logic       req_timeout;
`endif

  int checks = 0;
  int failures = 0;

  ar_int7_sequencer #(.NBP(4), .HOLDOFF(16), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .boot       (boot),
    .freeze_btn (freeze_btn),
    .reset_trap (reset_trap),
    .bp_hit     (bp_hit),
    .bp_arm     (bp_arm),
    .int7_ack   (int7_ack),
    .exit_wr    (exit_wr),
    .ovl_clr    (ovl_clr),
    .int7       (int7),
    .active     (active),
    .ovl        (ovl),
    .cause      (cause),
    .bp_idx     (bp_idx),
    .busy       (busy)
`ifdef AR_REQ_TIMEOUT_EN
    ,
    .req_timeout(req_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1; enable = 1; boot = 0; freeze_btn = 0; reset_trap = 0;
    bp_arm = 0; bp_hit = 4'b0; int7_ack = 0; exit_wr = 0; ovl_clr = 0;

    // Reset state
    step(2);
    reset = 0;
    chk("rst_int7", int7, 0);
    chk("rst_active", active, 0);
    chk("rst_ovl", ovl, 0);
    chk("rst_cause", cause, CAUSE_NONE);
    chk("rst_bpidx", bp_idx, 0);
    chk("rst_busy", busy, 0);

    // Freeze edge, held high throughout
    freeze_btn = 1; step();
    chk("frz_int7", int7, 1);
    chk("frz_cause", cause, CAUSE_FREEZE);
    chk("frz_busy", busy, 1);
    step(3);
    chk("frz_int7_hold", int7, 1);
    int7_ack = 1; step(); int7_ack = 0;
    chk("ack_int7", int7, 0);
    chk("ack_active", active, 1);
    chk("ack_ovl", ovl, 1);
    step(40);
    chk("frozen_int7", int7, 0);
    chk("frozen_active", active, 1);
    ovl_clr = 1; step(); ovl_clr = 0;
    chk("ovlclr_ovl", ovl, 0);
    chk("ovlclr_active", active, 1);
    exit_wr = 1; step(); exit_wr = 0;
    chk("exit_active", active, 0);
    chk("exit_busy", busy, 1);
    step(20);
    chk("held_no_req_int7", int7, 0);
    chk("held_no_req_busy", busy, 0);
    freeze_btn = 0; step();

    // bp_arm gating
    bp_hit = 4'b1000; step(); bp_hit = 4'b0;
    chk("unarmed_int7", int7, 0);
    chk("unarmed_busy", busy, 0);
    bp_arm = 1; bp_hit = 4'b1000; step(); bp_hit = 4'b0;
    chk("armed_int7", int7, 1);
    chk("armed_cause", cause, CAUSE_BREAK);
    chk("armed_bpidx", bp_idx, 3);
    int7_ack = 1; step(); int7_ack = 0;
    chk("bp_ack_active", active, 1);

    // Exit with simultaneous ovl_clr, then holdoff window
    exit_wr = 1; ovl_clr = 1; step(); exit_wr = 0; ovl_clr = 0;
    chk("exit_both_ovl", ovl, 0);
    chk("exit_both_active", active, 0);
    bp_hit = 4'b0001;
    step(15);
    chk("hold15_busy", busy, 1);
    chk("hold15_int7", int7, 0);
    step();
    chk("hold16_int7", int7, 0);
    chk("hold16_busy", busy, 0);
    step();
    bp_hit = 4'b0;
    chk("hold17_int7", int7, 1);
    chk("hold17_bpidx", bp_idx, 0);

    // Ack collides with exit_wr/ovl_clr in REQ: ack wins
    int7_ack = 1; exit_wr = 1; ovl_clr = 1; step();
    int7_ack = 0; exit_wr = 0; ovl_clr = 0;
    chk("coll_int7", int7, 0);
    chk("coll_active", active, 1);
    chk("coll_ovl", ovl, 1);
    chk("coll_busy", busy, 1);
    exit_wr = 1; step(); exit_wr = 0;
    step(16);
    chk("ovl_kept_busy", busy, 0);
    chk("ovl_kept", ovl, 1);
    ovl_clr = 1; step(); ovl_clr = 0;
    chk("idle_ovlclr", ovl, 0);

    // Simultaneous requests: reset trap wins, bp_idx untouched
    reset_trap = 1; freeze_btn = 1; bp_hit = 4'b0110; step();
    reset_trap = 0; bp_hit = 4'b0;
    chk("simul_cause", cause, CAUSE_RESET);
    chk("simul_bpidx", bp_idx, 0);
    enable = 0; step(); enable = 1;
    chk("dis_cause", cause, CAUSE_NONE);
    chk("dis_busy", busy, 0);
    chk("dis_int7", int7, 0);
    bp_hit = 4'b0110; step(); bp_hit = 4'b0;
    chk("bp_only_cause", cause, CAUSE_BREAK);
    chk("bp_only_bpidx", bp_idx, 1);

    // Boot gating in IDLE
    enable = 0; freeze_btn = 0; step(); enable = 1; step();
    boot = 1; freeze_btn = 1; step();
    chk("boot_int7", int7, 0);
    chk("boot_cause", cause, CAUSE_NONE);
    boot = 0; step();
    chk("boot_after_int7", int7, 0);

    // Boot rising mid-sequence does not abort
    freeze_btn = 0; step(); freeze_btn = 1; step();
    chk("seq_int7", int7, 1);
    boot = 1; step();
    chk("seq_boot_int7", int7, 1);
    int7_ack = 1; step(); int7_ack = 0;
    chk("seq_boot_active", active, 1);
    boot = 0;

    // Reset while frozen with ovl set
    reset = 1; step(); reset = 0;
    chk("midrst_int7", int7, 0);
    chk("midrst_active", active, 0);
    chk("midrst_ovl", ovl, 0);
    chk("midrst_cause", cause, CAUSE_NONE);
    chk("midrst_busy", busy, 0);

`ifdef AR_REQ_TIMEOUT_EN
    chk("tmo_rst", req_timeout, 0);
    freeze_btn = 0; step(); freeze_btn = 1; step();
    chk("tmo_start_int7", int7, 1);
    step(15);
    chk("tmo_15_int7", int7, 1);
    chk("tmo_15_flag", req_timeout, 0);
    step();
    chk("tmo_16_int7", int7, 0);
    chk("tmo_16_flag", req_timeout, 1);
    chk("tmo_16_cause", cause, CAUSE_NONE);
    chk("tmo_16_busy", busy, 0);
    step(3);
    chk("tmo_sticky", req_timeout, 1);
    reset = 1; step(); reset = 0;
    chk("tmo_cleared", req_timeout, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ar_int7_sequencer.md
Name: ar_int7_sequencer

Overview:
Central controller for the freeze-cartridge NMI path. It arbitrates the freeze-button, reset-trap and NBP breakpoint-comparator requests into a single level-7 interrupt, and latches the winning cause into the status register. It sequences the cartridge through request, acknowledge, frozen and exit phases, driving the chip-RAM overlay and cartridge-active flags. It sits between the cartridge address/decode logic (request sources, CPU register strobes) and the CPU interrupt-level encoder.

Parameters:
NBP, 4, number of breakpoint comparator inputs (1..8)
HOLDOFF, 16, clk cycles after exit during which all requests are ignored (1..255)
TIMEOUT, 1024, clk cycles INT7 may stay unacknowledged, used only with AR_REQ_TIMEOUT_EN (16..65535)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  cartridge present/enabled; low forces IDLE and clears all outputs
boot  in  1  bootloader running; new requests are blocked while high
freeze_btn  in  1  freeze key level; block edge-detects it internally
reset_trap  in  1  first-write-after-reset hit, 1-clk pulse
bp_hit  in  NBP  breakpoint comparator hits, 1-clk pulses
bp_arm  in  1  breakpoint enable (mode[1])
int7_ack  in  1  CPU interrupt-acknowledge read cycle seen, 1-clk pulse
exit_wr  in  1  CPU write to mode register ($400000), 1-clk pulse
ovl_clr  in  1  CPU write to $400006, 1-clk pulse
int7  out  1  level-7 interrupt request
active  out  1  cartridge ROM/RAM visible (frozen)
ovl  out  1  chip-RAM overlay enable
cause  out  2  status code: 11 none, 00 freeze, 01 breakpoint, 10 reset trap
bp_idx  out  3  index of the breakpoint that fired (valid when cause=01)
busy  out  1  high in any state other than IDLE

Behaviour:
- All registers update on posedge clk.
- Reset or enable=0 has immediate effect. State becomes IDLE; int7, active and ovl become 0; cause becomes 11; bp_idx becomes 0; counters become 0. The freeze edge register is loaded with the current freeze_btn so no spurious edge is seen afterwards.
- freeze_req = freeze_btn & ~freeze_btn_q (rising edge).
- bp_req = bp_arm & |bp_hit.
- States: IDLE, REQ, FROZEN, HOLDOFF.
- IDLE:
  - If boot=0 and any request is present, arbitrate with fixed priority: reset_trap > freeze_req > bp_req.
  - Among breakpoints, the lowest set index wins.
  - Latch cause (and bp_idx for breakpoints), set int7=1 and go to REQ the next cycle. int7 is high on the first REQ cycle (1-clk latency from request).
  - Losing or simultaneous requests are dropped; there is no queue.
- REQ:
  - int7 stays high.
  - int7_ack -> int7=0, active=1, ovl=1, go to FROZEN.
  - exit_wr and ovl_clr are ignored in REQ. If ack coincides with either, the ack wins.
  - New requests are ignored.
- FROZEN:
  - ovl_clr -> ovl=0 and the state is unchanged.
  - exit_wr -> active=0 and go to HOLDOFF, with the counter loaded to HOLDOFF-1.
  - If exit_wr and ovl_clr arrive together, both take effect.
  - freeze_req and bp_req are ignored.
  - int7_ack has no effect.
- HOLDOFF:
  - Counter decrements each cycle. Transition to IDLE on the cycle it reads 0.
  - Requests in HOLDOFF are dropped.
  - ovl is not touched by exit_wr. If still set, it remains until ovl_clr, which is accepted in HOLDOFF and IDLE as well.
- cause is held until the next accepted request, or until reset/enable=0.
- boot rising while in REQ/FROZEN does not abort the sequence; boot only gates acceptance in IDLE.
- Counter widths are $clog2 of the parameter value; they never wrap (saturate at 0).

Optional Feature:
- Macro AR_REQ_TIMEOUT_EN.
- Defined:
  - A counter starts at TIMEOUT-1 on entry to REQ.
  - If it reaches 0 without int7_ack, int7=0, the block returns to IDLE, cause=11, and sticky output port req_timeout (1 bit) is set.
  - req_timeout is cleared only by reset/enable=0.
- Undefined: REQ waits indefinitely; the req_timeout port and counter are absent.

Decomposition:
- Package ar_pkg:
  - state enum (IDLE/REQ/FROZEN/HOLDOFF)
  - cause codes CAUSE_NONE=2'b11, CAUSE_FREEZE=2'b00, CAUSE_BREAK=2'b01, CAUSE_RESET=2'b10
- Sub-module ar_bp_prio_enc: NBP-input lowest-index priority encoder producing hit flag and 3-bit index.

Test Plan:
- Freeze edge: freeze_btn 0->1 held 50 cycles in IDLE -> int7=1 one cycle later, cause=00. int7_ack -> int7=0, active=1, ovl=1. No second request while held.
- Simultaneous requests: reset_trap, freeze edge and bp_hit=4'b0110 in the same cycle with bp_arm=1 -> cause=10 and bp_idx unchanged. Repeat without reset_trap and freeze -> cause=01, bp_idx=1.
- bp_arm gating: bp_hit=4'b1000 with bp_arm=0 -> no int7. Same stimulus with bp_arm=1 -> int7=1, bp_idx=3.
- Exit and holdoff with HOLDOFF=16: in FROZEN, ovl_clr then exit_wr -> ovl=0, active=0. bp_hit during the next 16 cycles is ignored; bp_hit on cycle 17 raises int7.
- Ack collision and boot: int7_ack together with exit_wr in REQ -> FROZEN with active=1. Freeze edge with boot=1 -> no int7, cause stays 11.
- Reset mid-operation: assert reset in FROZEN with ovl=1 -> next cycle int7=0, active=0, ovl=0, cause=11, busy=0. With AR_REQ_TIMEOUT_EN and TIMEOUT=16, no ack -> int7 drops after 16 cycles and req_timeout=1.
